lfsr_sng_et: RTL and testbench

// - Multi-channel LFSR stochastic number generator (SNG) with run control and early termination (ET).
// - Each run latches N binary probabilities and emits up to LEN bitstream cycles per channel.
// - Output uses a valid/ready handshake; a run ends early on an external ET stop.
// - Sits between the operand register file and the SC datapath; ET control logic reads the ones counts.

---
 rtl/lfsr_sng_et_pkg.sv | 40 ++++
 rtl/lfsr_sng_et_if.sv | 28 ++
 rtl/lfsr_sng_et_lfsr_step.sv | 14 +
 rtl/lfsr_sng_et.sv | 143 ++++++++++++++
 tb/tb_lfsr_sng_et.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/lfsr_sng_et_pkg.sv
// Shared types and helpers for the LFSR stochastic number generator.
// Polynomial tap masks: next = {state[W-2:0], ^(state & mask)}.
package lfsr_sng_et_pkg;

  typedef enum logic [1:0] {
    SNG_INDEP  = 2'd0,
    SNG_SHARED = 2'd1,
    SNG_ROT    = 2'd2
  } sng_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sng_state_e;

  // Maximal-length tap masks for the shift-left Fibonacci form used here.
  localparam logic [31:0] POLY_W3 = 32'h0000_0005;
  localparam logic [31:0] POLY_W4 = 32'h0000_0009;

  function automatic logic [31:0] default_poly(input int w);
    case (w)
      3:       return POLY_W3;
      4:       return POLY_W4;
      default: return (32'h1 << (w - 1)) | 32'h1;
    endcase
  endfunction

  // Rotate the low w bits of v left by k (k taken modulo w).
  function automatic logic [31:0] rotl(input logic [31:0] v, input int k, input int w);
    logic [31:0] mask;
    logic [31:0] vm;
    int          r;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    vm   = v & mask;
    r    = k % w;
    if (r == 0) return vm;
    return ((vm << r) | (vm >> (w - r))) & mask;
  endfunction

endpackage

// File: rtl/lfsr_sng_et_if.sv
// Run-request and bitstream handshake bundle for lfsr_sng_et.
// The slave side is the generator; the master side requests runs and consumes beats.
interface lfsr_sng_et_if #(
  parameter int W = 4,
  parameter int N = 2
);
  logic                  start;
  logic                  ready;
  logic [N-1:0][W-1:0]   Bxs;
  logic [W-1:0]          len;
  logic                  et_stop;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          Xs;
  logic                  last;
  logic [N-1:0][W:0]     ones;
  logic [W:0]            beats;

  modport master (
    output start, Bxs, len, et_stop, out_ready,
    input  ready, out_valid, Xs, last, ones, beats
  );

  modport slave (
    input  start, Bxs, len, et_stop, out_ready,
    output ready, out_valid, Xs, last, ones, beats
  );
endinterface

// File: rtl/lfsr_sng_et_lfsr_step.sv
// Combinational one-step Fibonacci LFSR: shift left, parity of tapped bits enters at bit 0.
module lfsr_sng_et_lfsr_step
  import lfsr_sng_et_pkg::*;
#(
  parameter int           W    = 4,
  parameter logic [W-1:0] POLY = W'(default_poly(W))
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  assign nxt = {cur[W-2:0], ^(cur & POLY)};

endmodule

// File: rtl/lfsr_sng_et.sv
// Multi-channel LFSR stochastic number generator with run control and early termination.
// One beat carries one bit per channel; ones/beats count accepted beats of the current run.
module lfsr_sng_et
  import lfsr_sng_et_pkg::*;
#(
  parameter int           W           = 4,
  parameter int           N           = 2,
  parameter logic [W-1:0] LFSR_POLY   = W'(default_poly(W)),
  parameter int           START_STATE = 1,
  parameter sng_mode_e    MODE        = SNG_INDEP
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_sng_et_if.slave  bus
);

  typedef logic [W-1:0] word_t;
  typedef logic [W:0]   cnt_t;

  localparam int   NL   = (MODE == SNG_INDEP) ? N : 1;
  localparam cnt_t MAXC = cnt_t'((1 << W) - 1);

  function automatic word_t seed_of(input int i);
    return word_t'(rotl(32'(START_STATE), i, W));
  endfunction

  function automatic word_t rot_w(input word_t v, input int i);
    return word_t'(rotl(32'(v), i, W));
  endfunction

  function automatic cnt_t inc_sat(input cnt_t v, input logic b);
    if (b && (v != MAXC)) return v + 1'b1;
    return v;
  endfunction

  sng_state_e           state_p1;
  word_t                s_p1   [NL];
  word_t                s_nxt  [NL];
  logic [N-1:0][W-1:0]  bx_p1;
  cnt_t                 len_eff_p1;
  logic                 vld_p1;
  logic [N-1:0]         xs_p1;
  logic                 last_len_p1;
  logic                 et_flag_p1;
  logic [N-1:0][W:0]    ones_p1;
  cnt_t                 beats_p1;

  logic [N-1:0]         xs_seed;
  logic [N-1:0]         xs_step;
  cnt_t                 len_eff_in;
  logic                 xfer;
  logic                 last_now;

  for (genvar g = 0; g < NL; g++) begin : g_lfsr
    lfsr_sng_et_lfsr_step #(.W(W), .POLY(LFSR_POLY)) u_step (
      .cur (s_p1[g]),
      .nxt (s_nxt[g])
    );
  end

  // Compare values: the seed feeds the first beat, the stepped state feeds later beats.
  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    word_t cmp_seed;
    word_t cmp_step;
    if (MODE == SNG_INDEP) begin : g_ind
      assign cmp_seed = seed_of(gi);
      assign cmp_step = s_nxt[gi];
    end else if (MODE == SNG_SHARED) begin : g_shr
      assign cmp_seed = seed_of(0);
      assign cmp_step = s_nxt[0];
    end else begin : g_rot
      assign cmp_seed = rot_w(seed_of(0), gi);
      assign cmp_step = rot_w(s_nxt[0], gi);
    end
    assign xs_seed[gi] = cmp_seed < bus.Bxs[gi];
    assign xs_step[gi] = cmp_step < bx_p1[gi];
  end

  assign len_eff_in = (bus.len == '0) ? MAXC : {1'b0, bus.len};
  assign xfer       = vld_p1 & bus.out_ready;
  // et_stop reaches last combinationally so a stop lands on the beat it arrives with.
  assign last_now   = vld_p1 & (last_len_p1 | et_flag_p1 | bus.et_stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= ST_IDLE;
      vld_p1      <= 1'b0;
      xs_p1       <= '0;
      last_len_p1 <= 1'b0;
      et_flag_p1  <= 1'b0;
      ones_p1     <= '0;
      beats_p1    <= '0;
      bx_p1       <= '0;
      len_eff_p1  <= '0;
      for (int i = 0; i < NL; i++) s_p1[i] <= seed_of(i);
    end else begin
      case (state_p1)
        ST_IDLE: begin
          if (bus.start) begin
            state_p1    <= ST_RUN;
            bx_p1       <= bus.Bxs;
            len_eff_p1  <= len_eff_in;
            vld_p1      <= 1'b1;
            xs_p1       <= xs_seed;
            last_len_p1 <= (len_eff_in == cnt_t'(1));
            et_flag_p1  <= 1'b0;
            ones_p1     <= '0;
            beats_p1    <= '0;
            for (int i = 0; i < NL; i++) s_p1[i] <= seed_of(i);
          end
        end
        ST_RUN: begin
          if (xfer) begin
            beats_p1 <= inc_sat(beats_p1, 1'b1);
            for (int i = 0; i < N; i++) ones_p1[i] <= inc_sat(ones_p1[i], xs_p1[i]);
            if (last_now) begin
              state_p1    <= ST_IDLE;
              vld_p1      <= 1'b0;
              xs_p1       <= '0;
              last_len_p1 <= 1'b0;
              et_flag_p1  <= 1'b0;
            end else begin
              for (int i = 0; i < NL; i++) s_p1[i] <= s_nxt[i];
              xs_p1       <= xs_step;
              last_len_p1 <= ((beats_p1 + 1'b1) == (len_eff_p1 - 1'b1));
            end
          end else if (bus.et_stop) begin
            et_flag_p1 <= 1'b1;
          end
        end
        default: state_p1 <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready     = (state_p1 == ST_IDLE);
  assign bus.out_valid = vld_p1;
  assign bus.Xs        = xs_p1;
  assign bus.last      = last_now;
  assign bus.ones      = ones_p1;
  assign bus.beats     = beats_p1;

endmodule

// File: tb/tb_lfsr_sng_et.sv
// Directed bench: an INDEP and a SHARED generator driven in lockstep, checked against a state table.
module tb_lfsr_sng_et;
  import lfsr_sng_et_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0][3:0] bxs = '0;
  logic [3:0]      len = '0;
  logic            et_stop = 1'b0;
  logic            out_ready = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  // Hand-derived W=4 sequence from seed 1 with taps at bits 3 and 0.
  int seq [15] = '{1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8};

  lfsr_sng_et_if #(.W(4), .N(2)) if_ind ();
  lfsr_sng_et_if #(.W(4), .N(2)) if_sh ();

  assign if_ind.start = start;      assign if_sh.start = start;
  assign if_ind.Bxs = bxs;          assign if_sh.Bxs = bxs;
  assign if_ind.len = len;          assign if_sh.len = len;
  assign if_ind.et_stop = et_stop;  assign if_sh.et_stop = et_stop;
  assign if_ind.out_ready = out_ready; assign if_sh.out_ready = out_ready;

  lfsr_sng_et #(.W(4), .N(2), .START_STATE(1), .MODE(SNG_INDEP)) dut_ind (
    .clk (clk), .rst (rst), .bus (if_ind.slave)
  );
  lfsr_sng_et #(.W(4), .N(2), .START_STATE(1), .MODE(SNG_SHARED)) dut_sh (
    .clk (clk), .rst (rst), .bus (if_sh.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, {if_ind.ready, if_sh.ready}, 2'b11);
    chk({nm, "_valid"}, {if_ind.out_valid, if_sh.out_valid}, 2'b00);
    chk({nm, "_xs"},    {if_ind.Xs, if_sh.Xs}, 4'h0);
    chk({nm, "_last"},  {if_ind.last, if_sh.last}, 2'b00);
  endtask

  // One run: et_k is the 0-based beat that sees et_stop (-1 none); tog alternates out_ready 1,0,...
  task automatic do_run(input int b0, input int b1, input int ln, input int et_k, input bit tog,
                        input int exp_beats, input int exp_o0, input int exp_o1, input string nm);
    int k, cyc, leff, st0, st1;
    int oi0, oi1, os0, os1;
    bit sticky, done, exp_last;
    logic [1:0] ex_i, ex_s;
    k = 0; cyc = 0; sticky = 0; done = 0;
    oi0 = 0; oi1 = 0; os0 = 0; os1 = 0;
    leff = (ln == 0) ? 15 : ln;
    @(posedge clk); #1;
    chk({nm, "_ready_pre"}, {if_ind.ready, if_sh.ready}, 2'b11);
    start = 1'b1; bxs = {4'(b1), 4'(b0)}; len = 4'(ln);
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 100) begin
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      et_stop   = (k == et_k) && (!tog || !out_ready);
      #1;
      chk({nm, "_valid"}, {if_ind.out_valid, if_sh.out_valid, if_ind.ready}, 3'b110);
      st0  = seq[k % 15];
      st1  = seq[(k + 12) % 15];
      ex_i = {logic'(st1 < b1), logic'(st0 < b0)};
      ex_s = {logic'(st0 < b1), logic'(st0 < b0)};
      chk({nm, "_xs_ind"}, if_ind.Xs, ex_i);
      chk({nm, "_xs_sh"},  if_sh.Xs,  ex_s);
      exp_last = (k == leff - 1) || sticky || et_stop;
      chk({nm, "_last"}, {if_ind.last, if_sh.last}, {exp_last, exp_last});
      if (out_ready) begin
        oi0 += ex_i[0]; oi1 += ex_i[1]; os0 += ex_s[0]; os1 += ex_s[1];
        k++;
        if (exp_last) done = 1;
      end else if (et_stop) begin
        sticky = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    et_stop = 1'b0; out_ready = 1'b1;
    chk_idle({nm, "_end"});
    chk({nm, "_beats_ind"}, if_ind.beats, exp_beats);
    chk({nm, "_beats_sh"},  if_sh.beats,  exp_beats);
    chk({nm, "_ones_ind0"}, if_ind.ones[0], oi0);
    chk({nm, "_ones_ind1"}, if_ind.ones[1], oi1);
    chk({nm, "_ones_sh0"},  if_sh.ones[0],  os0);
    chk({nm, "_ones_sh1"},  if_sh.ones[1],  os1);
    if (exp_o0 >= 0) begin
      chk({nm, "_ones_hand0"}, if_ind.ones[0], exp_o0);
      chk({nm, "_ones_hand1"}, if_sh.ones[1],  exp_o1);
    end
    @(posedge clk); #1;
    chk({nm, "_no_extra"}, {if_ind.out_valid, if_sh.out_valid}, 2'b00);
    chk({nm, "_beats_hold"}, if_sh.beats, exp_beats);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_ones", {if_ind.ones, if_sh.ones}, 0);
    chk("reset_beats", {if_ind.beats, if_sh.beats}, 0);
    rst = 1'b0;

    do_run(8, 8, 0, -1, 1'b0, 15, 7, 7, "full_b8");
    do_run(5, 9, 0, -1, 1'b0, 15, 4, 8, "full_b5_9");
    do_run(8, 8, 6, 2, 1'b0, 3, -1, -1, "et_b3");
    do_run(3, 10, 5, -1, 1'b0, 5, -1, -1, "len5");
    do_run(8, 12, 6, 2, 1'b1, 3, -1, -1, "stall_et");
    do_run(0, 15, 0, -1, 1'b0, 15, 0, 14, "bx_edges");

    // Reset in the middle of a run, then repeat the first run from seed.
    @(posedge clk); #1;
    start = 1'b1; bxs = {4'd8, 4'd8}; len = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_valid", {if_ind.out_valid, if_sh.out_valid}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_ones", {if_ind.ones, if_sh.ones}, 0);
    chk("mid_rst_beats", {if_ind.beats, if_sh.beats}, 0);
    do_run(8, 8, 0, -1, 1'b0, 15, 7, 7, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
